// File: rtl/sparse_phase_profiler.sv
// Phase monitor/sequencer for sparse-tile streams: snoops write handshakes, waits for
// every channel's end-of-stream token, holds a programmable gap, then gates the read phase.
module sparse_phase_profiler #(
  parameter int                    DATA_WIDTH = 17,
  parameter int                    NUM_WR     = 1,
  parameter int                    NUM_RD     = 2,
  parameter int                    CNT_WIDTH  = 32,
  parameter int                    GAP_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WR-1:0]            wr_valid,
  input  logic [NUM_WR-1:0]            wr_ready,
  input  logic                         rd_trigger,
  input  logic [NUM_RD-1:0]            rd_done,
  input  logic [GAP_WIDTH-1:0]         gap_cfg,
  output logic                         read_gate,
  output logic [2:0]                   phase,
  output logic [CNT_WIDTH-1:0]         write_cycles,
  output logic [CNT_WIDTH-1:0]         read_cycles,
  output logic [NUM_WR-1:0]            eos_seen,
  output logic                         protocol_err
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WRITE = 3'd1,
    PH_GAP   = 3'd2,
    PH_READ  = 3'd3,
    PH_DONE  = 3'd4
  } phase_e;

  phase_e                phase_r, phase_nx_s;
  logic [CNT_WIDTH-1:0]  wcnt_r, wcnt_nx_s;
  logic [CNT_WIDTH-1:0]  rcnt_r, rcnt_nx_s;
  logic [GAP_WIDTH-1:0]  gap_r, gap_nx_s;
  logic [NUM_WR-1:0]     eos_r, eos_nx_s;
  logic                  perr_r, perr_nx_s;
  logic                  gate_r, gate_nx_s;
  logic [NUM_WR-1:0]     hs_s, eos_hs_s;
  logic                  all_eos_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  for (genvar i = 0; i < NUM_WR; i++) begin : g_hs
    assign hs_s[i]     = wr_valid[i] & wr_ready[i];
    assign eos_hs_s[i] = hs_s[i] & (wr_data[i*DATA_WIDTH +: DATA_WIDTH] == DONE_TOKEN);
  end

  // Final tokens landing on the same edge as the last outstanding ones still complete the phase.
  assign all_eos_s = &(eos_r | eos_hs_s);

  // Next-state and next-counter logic for the phase sequencer.
  always_comb begin
    phase_nx_s = phase_r;
    wcnt_nx_s  = wcnt_r;
    rcnt_nx_s  = rcnt_r;
    gap_nx_s   = gap_r;
    eos_nx_s   = eos_r;
    perr_nx_s  = perr_r;
    case (phase_r)
      PH_IDLE: begin
        if (|wr_valid) begin
          wcnt_nx_s = sat_inc(wcnt_r);
          eos_nx_s  = eos_r | eos_hs_s;
          if (all_eos_s) begin
            phase_nx_s = PH_GAP;
            gap_nx_s   = gap_cfg;
          end else begin
            phase_nx_s = PH_WRITE;
          end
        end else begin
          phase_nx_s = PH_IDLE;
        end
      end
      PH_WRITE: begin
        wcnt_nx_s = sat_inc(wcnt_r);
        eos_nx_s  = eos_r | eos_hs_s;
        perr_nx_s = perr_r | (|(hs_s & eos_r));
        if (all_eos_s) begin
          phase_nx_s = PH_GAP;
          gap_nx_s   = gap_cfg;
        end else begin
          phase_nx_s = PH_WRITE;
        end
      end
      PH_GAP: begin
        if (gap_r != {GAP_WIDTH{1'b0}}) begin
          gap_nx_s = gap_r - {{(GAP_WIDTH-1){1'b0}}, 1'b1};
        end else if (rd_trigger) begin
          phase_nx_s = PH_READ;
        end else begin
          phase_nx_s = PH_GAP;
        end
      end
      PH_READ: begin
        if (&rd_done) begin
          phase_nx_s = PH_DONE;
        end else begin
          rcnt_nx_s = sat_inc(rcnt_r);
        end
      end
      PH_DONE: begin
        phase_nx_s = PH_DONE;
      end
      default: begin
        phase_nx_s = PH_IDLE;
      end
    endcase
    gate_nx_s = (phase_nx_s == PH_READ) || (phase_nx_s == PH_DONE);
  end

  // State and counter registers; flush only acts while clk_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= PH_IDLE;
      wcnt_r  <= {CNT_WIDTH{1'b0}};
      rcnt_r  <= {CNT_WIDTH{1'b0}};
      gap_r   <= {GAP_WIDTH{1'b0}};
      eos_r   <= {NUM_WR{1'b0}};
      perr_r  <= 1'b0;
      gate_r  <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        phase_r <= PH_IDLE;
        wcnt_r  <= {CNT_WIDTH{1'b0}};
        rcnt_r  <= {CNT_WIDTH{1'b0}};
        gap_r   <= {GAP_WIDTH{1'b0}};
        eos_r   <= {NUM_WR{1'b0}};
        perr_r  <= 1'b0;
        gate_r  <= 1'b0;
      end else begin
        phase_r <= phase_nx_s;
        wcnt_r  <= wcnt_nx_s;
        rcnt_r  <= rcnt_nx_s;
        gap_r   <= gap_nx_s;
        eos_r   <= eos_nx_s;
        perr_r  <= perr_nx_s;
        gate_r  <= gate_nx_s;
      end
    end
  end

  assign phase        = phase_r;
  assign read_gate    = gate_r;
  assign write_cycles = wcnt_r;
  assign read_cycles  = rcnt_r;
  assign eos_seen     = eos_r;
  assign protocol_err = perr_r;

endmodule

// File: tb/tb_sparse_phase_profiler.sv
// Directed bench: a single-channel instance and a two-channel instance with a 4-bit
// counter (to reach saturation) share clock, reset, flush and read-side controls.
module tb_sparse_phase_profiler;
  localparam int          DW       = 17;
  localparam logic [16:0] DONE_TOK = 17'h10100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clk_en, flush, rd_trigger;
  logic [1:0]    rd_done;
  logic [7:0]    gap_cfg;

  logic [DW-1:0] a_data;
  logic          a_valid, a_ready, a_gate, a_eos, a_perr;
  logic [2:0]    a_phase;
  logic [31:0]   a_wc, a_rc;

  logic [2*DW-1:0] b_data;
  logic [1:0]      b_valid, b_ready, b_eos;
  logic            b_gate, b_perr;
  logic [2:0]      b_phase;
  logic [3:0]      b_wc, b_rc;

  int n_tests = 0;
  int n_fail  = 0;

  sparse_phase_profiler #(.DATA_WIDTH(DW), .NUM_WR(1), .NUM_RD(2), .CNT_WIDTH(32),
                          .GAP_WIDTH(8), .DONE_TOKEN(DONE_TOK)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .wr_data(a_data), .wr_valid(a_valid), .wr_ready(a_ready),
    .rd_trigger(rd_trigger), .rd_done(rd_done), .gap_cfg(gap_cfg),
    .read_gate(a_gate), .phase(a_phase), .write_cycles(a_wc), .read_cycles(a_rc),
    .eos_seen(a_eos), .protocol_err(a_perr));

  sparse_phase_profiler #(.DATA_WIDTH(DW), .NUM_WR(2), .NUM_RD(2), .CNT_WIDTH(4),
                          .GAP_WIDTH(8), .DONE_TOKEN(DONE_TOK)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .wr_data(b_data), .wr_valid(b_valid), .wr_ready(b_ready),
    .rd_trigger(rd_trigger), .rd_done(rd_done), .gap_cfg(gap_cfg),
    .read_gate(b_gate), .phase(b_phase), .write_cycles(b_wc), .read_cycles(b_rc),
    .eos_seen(b_eos), .protocol_err(b_perr));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [16:0] toks [5];

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; rd_trigger = 1'b0;
    rd_done = 2'b00; gap_cfg = 8'd0;
    a_data = '0; a_valid = 1'b0; a_ready = 1'b0;
    b_data = '0; b_valid = 2'b00; b_ready = 2'b00;
    toks[0] = 17'd3; toks[1] = 17'd5; toks[2] = 17'd9; toks[3] = 17'd12; toks[4] = DONE_TOK;

    ticks(2);
    check_val("rst_phase", {29'd0, a_phase}, 32'd0);
    check_val("rst_gate", {31'd0, a_gate}, 32'd0);
    check_val("rst_wc", a_wc, 32'd0);
    check_val("rst_rc", a_rc, 32'd0);
    check_val("rst_eos", {31'd0, a_eos}, 32'd0);
    check_val("rst_perr", {31'd0, a_perr}, 32'd0);
    check_val("rst_b_phase", {29'd0, b_phase}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single channel: five tokens, gap of 10
    gap_cfg = 8'd10; rd_trigger = 1'b1; a_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_data = toks[k];
      tick();
      if (k == 0) begin
        check_val("a_first_phase", {29'd0, a_phase}, 32'd1);
        check_val("a_first_wc", a_wc, 32'd1);
      end
    end
    a_valid = 1'b0;
    check_val("a_gap_phase", {29'd0, a_phase}, 32'd2);
    check_val("a_wc5", a_wc, 32'd5);
    check_val("a_eos1", {31'd0, a_eos}, 32'd1);
    ticks(10);
    check_val("a_gap_hold", {29'd0, a_phase}, 32'd2);
    check_val("a_gap_gate", {31'd0, a_gate}, 32'd0);
    tick();
    check_val("a_read_phase", {29'd0, a_phase}, 32'd3);
    check_val("a_read_gate", {31'd0, a_gate}, 32'd1);
    check_val("a_read_rc0", a_rc, 32'd0);
    for (int i = 0; i < 20; i++) begin
      rd_done = (i >= 17) ? 2'b10 : 2'b00;
      tick();
    end
    check_val("a_partial_done_phase", {29'd0, a_phase}, 32'd3);
    check_val("a_rc20", a_rc, 32'd20);
    rd_done = 2'b11;
    tick();
    check_val("a_done_phase", {29'd0, a_phase}, 32'd4);
    check_val("a_done_rc", a_rc, 32'd20);
    check_val("a_done_gate", {31'd0, a_gate}, 32'd1);
    a_valid = 1'b1; a_data = 17'd5;
    ticks(3);
    a_valid = 1'b0;
    check_val("a_done_frozen_phase", {29'd0, a_phase}, 32'd4);
    check_val("a_done_frozen_wc", a_wc, 32'd5);
    check_val("a_done_frozen_rc", a_rc, 32'd20);
    check_val("a_done_perr", {31'd0, a_perr}, 32'd0);
    do_flush();
    check_val("a_flush_phase", {29'd0, a_phase}, 32'd0);
    check_val("a_flush_gate", {31'd0, a_gate}, 32'd0);
    check_val("a_flush_wc", a_wc, 32'd0);
    check_val("a_flush_rc", a_rc, 32'd0);
    check_val("a_flush_eos", {31'd0, a_eos}, 32'd0);
    rd_done = 2'b00;

    // DONE_TOKEN on the first IDLE edge, zero gap, delayed trigger
    gap_cfg = 8'd0; rd_trigger = 1'b0;
    a_valid = 1'b1; a_data = DONE_TOK;
    tick();
    a_valid = 1'b0;
    check_val("a_direct_gap", {29'd0, a_phase}, 32'd2);
    check_val("a_direct_wc1", a_wc, 32'd1);
    ticks(4);
    check_val("a_trig_wait", {29'd0, a_phase}, 32'd2);
    rd_trigger = 1'b1;
    tick();
    check_val("a_trig_read", {29'd0, a_phase}, 32'd3);
    check_val("a_trig_gate", {31'd0, a_gate}, 32'd1);
    rd_done = 2'b11;
    tick();
    check_val("a_instant_done", {29'd0, a_phase}, 32'd4);
    check_val("a_instant_rc0", a_rc, 32'd0);
    rd_done = 2'b00;
    do_flush();

    // async reset while in READ
    a_valid = 1'b1; a_data = DONE_TOK;
    tick();
    a_valid = 1'b0;
    tick();
    ticks(3);
    check_val("a_mid_read_rc", a_rc, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("a_async_phase", {29'd0, a_phase}, 32'd0);
    check_val("a_async_gate", {31'd0, a_gate}, 32'd0);
    check_val("a_async_wc", a_wc, 32'd0);
    check_val("a_async_rc", a_rc, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_trigger = 1'b0;
    tick();

    // clock enable freeze in WRITE
    a_valid = 1'b1; a_data = 17'd3;
    ticks(2);
    check_val("a_en_wc2", a_wc, 32'd2);
    clk_en = 1'b0;
    ticks(5);
    check_val("a_en_frozen_wc", a_wc, 32'd2);
    check_val("a_en_frozen_phase", {29'd0, a_phase}, 32'd1);
    clk_en = 1'b1;
    tick();
    check_val("a_en_resume_wc", a_wc, 32'd3);
    a_valid = 1'b0;
    do_flush();

    // two channels, ready toggling, eos at edges 3 and 7
    for (int e = 0; e < 8; e++) begin
      b_ready = (e % 2 == 1) ? 2'b11 : 2'b00;
      b_valid[0] = (e <= 3);
      b_data[DW-1:0] = (e == 3) ? DONE_TOK : 17'(e + 1);
      b_valid[1] = 1'b1;
      b_data[2*DW-1:DW] = (e == 7) ? DONE_TOK : 17'(e + 20);
      tick();
      if (e == 3) begin
        check_val("b_eos_ch0", {30'd0, b_eos}, 32'd1);
        check_val("b_still_write", {29'd0, b_phase}, 32'd1);
      end
    end
    b_valid = 2'b00;
    check_val("b_gap_phase", {29'd0, b_phase}, 32'd2);
    check_val("b_wc8", {28'd0, b_wc}, 32'd8);
    check_val("b_eos_all", {30'd0, b_eos}, 32'd3);
    check_val("b_no_perr", {31'd0, b_perr}, 32'd0);
    do_flush();

    // token on ch0 after its eos
    b_ready = 2'b11; b_valid = 2'b11;
    b_data[DW-1:0] = DONE_TOK; b_data[2*DW-1:DW] = 17'd1;
    tick();
    check_val("b_pe_eos", {30'd0, b_eos}, 32'd1);
    b_data[DW-1:0] = 17'd5; b_data[2*DW-1:DW] = 17'd2;
    tick();
    check_val("b_pe_flag", {31'd0, b_perr}, 32'd1);
    check_val("b_pe_wait", {29'd0, b_phase}, 32'd1);
    b_valid = 2'b10; b_data[2*DW-1:DW] = DONE_TOK;
    tick();
    check_val("b_pe_gap", {29'd0, b_phase}, 32'd2);
    check_val("b_pe_sticky", {31'd0, b_perr}, 32'd1);
    check_val("b_pe_wc", {28'd0, b_wc}, 32'd3);
    b_valid = 2'b00;
    do_flush();
    check_val("b_pe_flushed", {31'd0, b_perr}, 32'd0);

    // simultaneous final tokens
    b_valid = 2'b11; b_data[DW-1:0] = 17'd1; b_data[2*DW-1:DW] = 17'd1;
    tick();
    b_data[DW-1:0] = DONE_TOK; b_data[2*DW-1:DW] = DONE_TOK;
    tick();
    b_valid = 2'b00;
    check_val("b_sim_gap", {29'd0, b_phase}, 32'd2);
    check_val("b_sim_wc", {28'd0, b_wc}, 32'd2);
    check_val("b_sim_eos", {30'd0, b_eos}, 32'd3);
    do_flush();

    // 4-bit write counter saturates
    b_ready = 2'b00; b_valid = 2'b01; b_data[DW-1:0] = 17'd1;
    ticks(20);
    check_val("b_sat_wc", {28'd0, b_wc}, 32'd15);
    check_val("b_sat_phase", {29'd0, b_phase}, 32'd1);
    b_valid = 2'b00;
    do_flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_phase_profiler.md
Name: sparse_phase_profiler

Overview:
- Synthesizable, parametrised phase monitor/sequencer for sparse-tile streams: snoops NUM_WR ready/valid write streams, detects per-channel DONE_TOKEN, enforces a programmable gap, then opens a read gate that releases upstream position traffic.
- Counts write-phase and read-phase cycles until every read sink reports done.
- Sits beside a fiber_access/buffet tile; lets on-chip profiling and staged write-then-read sequencing replace bench-side FSMs.

Parameters:
- DATA_WIDTH, 17, stream token width
- NUM_WR, 1, snooped write channels
- NUM_RD, 2, read sinks whose done flags end the read phase
- CNT_WIDTH, 32, cycle counter width
- GAP_WIDTH, 8, gap counter width
- DONE_TOKEN, 17'h10100, end-of-stream token value

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global enable; low freezes all state
- flush  in  1  synchronous clear to IDLE
- wr_data  in  NUM_WR*DATA_WIDTH  snooped write tokens, channel i at [i*DW +: DW]
- wr_valid  in  NUM_WR  snooped valids
- wr_ready  in  NUM_WR  snooped readies
- rd_trigger  in  1  upstream read-source valid; required to leave GAP
- rd_done  in  NUM_RD  per-sink done flags
- gap_cfg  in  GAP_WIDTH  gap length in cycles
- read_gate  out  1  high in READ and DONE; ANDed externally into read-source valid/ready
- phase  out  3  one-hot-free encoding: IDLE=0, WRITE=1, GAP=2, READ=3, DONE=4
- write_cycles  out  CNT_WIDTH  write-phase cycle count
- read_cycles  out  CNT_WIDTH  read-phase cycle count
- eos_seen  out  NUM_WR  per-channel DONE_TOKEN handshake observed
- protocol_err  out  1  sticky: handshake on a channel after its eos

Behaviour:
- Reset (rst_n low, async): phase=IDLE, read_gate=0, counters=0, eos_seen=0, protocol_err=0, gap counter=0. flush with clk_en high has identical sync effect; flush wins over all other events.
- clk_en low: no register updates, outputs hold.
- hs[i] = wr_valid[i] & wr_ready[i]; eos_hs[i] = hs[i] & (wr_data_i == DONE_TOKEN).
- IDLE: any wr_valid -> WRITE; that edge increments write_cycles. eos_hs in the same edge also recorded.
- WRITE: write_cycles +1 every edge. eos_seen[i] set on eos_hs[i]. hs[i] with eos_seen[i] already set -> protocol_err=1 (sticky until reset/flush). When (eos_seen | eos_hs) all ones -> GAP; that edge is counted. Simultaneous final tokens on several channels handled in one edge. NUM_WR=1 with DONE_TOKEN in the very first IDLE edge -> straight to GAP, write_cycles=1.
- Entering GAP loads gap counter with gap_cfg. GAP: counter>0 -> decrement; counter==0 & rd_trigger -> READ; counter==0 & !rd_trigger -> wait. gap_cfg=0 gives READ on first GAP edge with rd_trigger.
- READ: read_gate=1 (registered from phase, asserted the cycle phase==READ). If &rd_done -> DONE without incrementing; else read_cycles +1.
- DONE: read_gate stays 1, counters frozen, holds until flush/reset. New write traffic ignored.
- Counters saturate at all ones, no wrap.
- rd_done bits already high on READ entry -> DONE on first READ edge, read_cycles=0.

Test Plan:
- NUM_WR=1, ready=1, tokens 3,5,9,12,DONE_TOKEN on consecutive edges, gap_cfg=10, rd_trigger=1 -> write_cycles=5, phase=GAP for 11 edges, read_gate rises next cycle.
- rd_done={0,0} for 20 READ edges, then {1,1} -> read_cycles=20, phase=DONE, read_gate stays 1; rd_done={1,0} only -> stays READ, counting.
- NUM_WR=2, ch0 eos at edge 3, ch1 eos at edge 7, ready toggling 50% -> GAP entered at edge 7, write_cycles=8 (IDLE edge 0 through 7), eos_seen=2'b11.
- ch0 sends token after its DONE_TOKEN while ch1 still writing -> protocol_err=1, FSM still waits for ch1.
- gap_cfg=0, rd_trigger low 4 edges then high -> READ exactly on the edge rd_trigger high.
- Async rst_n mid-READ, and separately flush in DONE -> all outputs back to reset values; clk_en low for 5 cycles in WRITE -> write_cycles unchanged.
